debounce_sync: RTL and testbench
================================

# debounce_sync

Conditions a raw, asynchronous, possibly bouncing single-bit input into a clean, clock-synchronous level for a downstream D flip-flop's `d_in`. The input passes through a flop synchronizer chain and then a counter-based debounce state machine. The output changes only after the synchronized input has disagreed with it for a fixed number of consecutive cycles. Single-cycle rise/fall pulses and a saturating glitch counter are provided for downstream logic and debug.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth; legal range 2–4.
- `STABLE_CYCLES`, default 4: consecutive mismatching samples required to accept a new level; minimum 2.
- `RESET_LEVEL`, default 1'b0: value of the synchronizer flops and `d_out` during reset.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; asserts immediately, deasserts synchronously to `clk`.
- `raw_in` in 1: asynchronous raw input.
- `d_out` out 1: debounced level; drives the downstream flop's `d_in`.
- `rise_pulse` out 1: high for exactly one cycle when `d_out` goes 0→1.
- `fall_pulse` out 1: high for exactly one cycle when `d_out` goes 1→0.
- `busy` out 1: high while a candidate transition is being qualified.
- `glitch_count` out 8: number of aborted candidate transitions; saturates at 255.

## Operation
- The synchronizer chain samples `raw_in`. `synced` is the last-stage output. No logic reads earlier stages.
- FSM states:
  - `STABLE_LO`: `d_out`=0.
  - `WAIT_HI`: qualifying a rise.
  - `STABLE_HI`: `d_out`=1.
  - `WAIT_LO`: qualifying a fall.
- `STABLE_LO` with `synced`=1 → `WAIT_HI`, `cnt`<=1. With `synced`=0 → stay.
- `WAIT_HI`:
  - `synced`=1 and `cnt`==`STABLE_CYCLES`-1 → `STABLE_HI`; `d_out`<=1, `rise_pulse`<=1, `cnt`<=0.
  - `synced`=1 otherwise → `cnt`<=`cnt`+1.
  - `synced`=0 → `STABLE_LO`; `cnt`<=0; `glitch_count`<=`glitch_count`+1 unless already 255.
- `STABLE_HI`/`WAIT_LO` mirror the above with polarity inverted and `fall_pulse`.
- `busy` = state is `WAIT_HI` or `WAIT_LO` (registered-state decode).
- `cnt` width is $clog2(`STABLE_CYCLES`). `cnt` never exceeds `STABLE_CYCLES`-1.
- `rise_pulse` and `fall_pulse` are never high together. Each pulse is high in the same cycle that `d_out` first shows the new level.
- `d_out`, `rise_pulse` and `fall_pulse` are registered outputs. No combinational path from `raw_in` to any output.

## Timing
- Reset values: synchronizer flops = `RESET_LEVEL`; `d_out` = `RESET_LEVEL`; state = `STABLE_HI` if `RESET_LEVEL`=1, else `STABLE_LO`; `cnt`=0; `rise_pulse`=0; `fall_pulse`=0; `busy`=0; `glitch_count`=0.
- Latency:
  - If `raw_in` changes and then holds, `d_out` changes at the (`SYNC_STAGES`+`STABLE_CYCLES`)-th rising edge, counting the first edge that samples the new level.
  - Defaults: 6th edge, i.e. 60 time units at a 10-unit clock.
- A pulse on `raw_in` shorter than `STABLE_CYCLES` synced cycles never changes `d_out` and increments `glitch_count` by 1.
- Bounce in `WAIT_*`: each return to the old level aborts and counts once. Re-qualification restarts from `cnt`=1.
- Reset asserted during `WAIT_*`:
  - immediate return to reset state;
  - no pulse;
  - `glitch_count` cleared, not incremented.
- Reset deassertion with `raw_in` ≠ `RESET_LEVEL`: normal qualification; first possible `d_out` change after full latency.
- `glitch_count` at 255: holds; further aborts do not wrap.

## Structure
- Package `debounce_pkg`:
  - `state_t` enum {`STABLE_LO`, `WAIT_HI`, `STABLE_HI`, `WAIT_LO`};
  - `GLITCH_W`=8;
  - default parameter constants.
- Sub-module `sync_chain` (params `STAGES`, `RESET_LEVEL`; ports `clk`, `reset`, `async_in`, `sync_out`). It is reusable for any other asynchronous inputs.
- Top `debounce_sync` instantiates `sync_chain` and contains the FSM, counter and glitch counter.

## Test plan
- Reset held 2 cycles with `raw_in`=0, then released → `d_out`=0, `busy`=0, `glitch_count`=0, both pulses 0 throughout.
- `raw_in` 0→1 held → `d_out`=1 on 6th sampling edge; `rise_pulse`=1 for exactly that cycle; `busy`=1 for the 3 preceding cycles.
- `raw_in` high for 2 cycles then low → `d_out` stays 0; `glitch_count`=1; no pulse.
- Bounce 1,0,1,0,1 (one cycle each), then hold 1 → two aborts, `glitch_count`=2; `d_out`=1 after 4 consecutive synced 1s.
- Reset asserted at a falling edge mid-`WAIT_HI` → `d_out`, `busy` and `glitch_count` go to 0 before the next rising edge; no `rise_pulse`.
- 300 two-cycle glitches → `glitch_count` stops at 255; `d_out` unchanged at 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_sync input conditioner.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      WAIT_HI   = 2'd1,
      STABLE_HI = 2'd2,
      WAIT_LO   = 2'd3
   } state_t;

   localparam int   GLITCH_W          = 8;
   localparam int   DEF_SYNC_STAGES   = 2;
   localparam int   DEF_STABLE_CYCLES = 4;
   localparam logic DEF_RESET_LEVEL   = 1'b0;

   // Saturating increment so the debug counter sticks at all-ones.
   function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
      return (v == {GLITCH_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/debounce_sync_chain.sv
// Multi-flop synchronizer for one asynchronous bit; reusable for any async input.
module sync_chain #(
   parameter int   STAGES      = 2,
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   logic [STAGES-1:0] q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= {STAGES{RESET_LEVEL}};
      else       q <= {q[STAGES-2:0], async_in};
   end

   assign sync_out = q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw input; emits edge pulses and an abort counter.
//   state     | meaning
//   STABLE_LO | d_out = 0, watching for synced = 1
//   WAIT_HI   | qualifying a rise, cnt = consecutive 1 samples
//   STABLE_HI | d_out = 1, watching for synced = 0
//   WAIT_LO   | qualifying a fall, cnt = consecutive 0 samples
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int   STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter logic RESET_LEVEL   = DEF_RESET_LEVEL
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                raw_in,
   output logic                d_out,
   output logic                rise_pulse,
   output logic                fall_pulse,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_count
);

   localparam int             CNT_W    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam state_t         RST_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

   logic                synced;
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                d_out_d, rise_d, fall_d;
   logic [GLITCH_W-1:0] glitch_d;

   sync_chain #(
      .STAGES      (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
   ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (raw_in),
      .sync_out (synced)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= RST_STATE;
         cnt_q        <= '0;
         d_out        <= RESET_LEVEL;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         glitch_count <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         d_out        <= d_out_d;
         rise_pulse   <= rise_d;
         fall_pulse   <= fall_d;
         glitch_count <= glitch_d;
      end
   end

   // Outputs are computed one cycle ahead so the pulse lands with the new d_out.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      d_out_d  = d_out;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      glitch_d = glitch_count;
      case (state_q)
         STABLE_LO: begin
            if (synced) begin
               state_d = WAIT_HI;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT_HI: begin
            if (synced) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_HI;
                  d_out_d = 1'b1;
                  rise_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d  = STABLE_LO;
               cnt_d    = '0;
               glitch_d = sat_inc(glitch_count);
            end
         end
         STABLE_HI: begin
            if (!synced) begin
               state_d = WAIT_LO;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT_LO: begin
            if (!synced) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = STABLE_LO;
                  d_out_d = 1'b0;
                  fall_d  = 1'b1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d  = STABLE_HI;
               cnt_d    = '0;
               glitch_d = sat_inc(glitch_count);
            end
         end
         default: begin
            state_d = RST_STATE;
            cnt_d   = '0;
         end
      endcase
   end

   assign busy = (state_q == WAIT_HI) || (state_q == WAIT_LO);

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: vector table, corner sequences, random vs model.
module tb_debounce_sync;

   localparam int   SYNC   = 2;
   localparam int   STABLE = 4;
   localparam logic RL     = 1'b0;

   logic       clk, reset, raw_in;
   logic       d_out, rise_pulse, fall_pulse, busy;
   logic [7:0] glitch_count;

   int checks   = 0;
   int failures = 0;

   debounce_sync #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STABLE),
      .RESET_LEVEL   (RL)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .raw_in       (raw_in),
      .d_out        (d_out),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .busy         (busy),
      .glitch_count (glitch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: level changes after STABLE consecutive synced samples that disagree.
   logic q_model[$];
   logic m_d, m_rise, m_fall;
   int   m_run, m_glitch;

   task automatic model_reset();
      q_model.delete();
      for (int i = 0; i < SYNC; i++) q_model.push_back(RL);
      m_d = RL; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_glitch = 0;
   endtask

   task automatic model_step(input logic r);
      logic s;
      s = q_model.pop_front();
      q_model.push_back(r);
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (s != m_d) begin
         m_run++;
         if (m_run == STABLE) begin
            m_d    = s;
            m_rise = s;
            m_fall = !s;
            m_run  = 0;
         end
      end else begin
         if (m_run > 0 && m_glitch < 255) m_glitch++;
         m_run = 0;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Called at a falling edge; returns at the next falling edge after checking vs model.
   task automatic edge_step(input logic r, input logic rs);
      raw_in = r;
      reset  = rs;
      if (rs) model_reset();
      @(posedge clk);
      if (!rs) model_step(r);
      #1;
      chk("m_d_out",  32'(d_out),        32'(m_d));
      chk("m_busy",   32'(busy),         32'(m_run > 0));
      chk("m_rise",   32'(rise_pulse),   32'(m_rise));
      chk("m_fall",   32'(fall_pulse),   32'(m_fall));
      chk("m_glitch", 32'(glitch_count), 32'(m_glitch));
      @(negedge clk);
   endtask

   typedef struct {
      logic raw; logic rst;
      logic d; logic b; logic r; logic f; int g;
   } vec_t;

   function automatic vec_t mk(logic raw, logic rst, logic d, logic b, logic r, logic f, int g);
      vec_t v;
      v.raw = raw; v.rst = rst; v.d = d; v.b = b; v.r = r; v.f = f; v.g = g;
      return v;
   endfunction

   vec_t tbl[25];

   initial begin
      int   lat;
      logic r;

      // reset, rise after 6 edges, 2-cycle low glitch, then a real fall
      tbl[0]  = mk(0,1, 0,0,0,0, 0);  tbl[1]  = mk(0,1, 0,0,0,0, 0);
      tbl[2]  = mk(0,0, 0,0,0,0, 0);  tbl[3]  = mk(0,0, 0,0,0,0, 0);
      tbl[4]  = mk(1,0, 0,0,0,0, 0);  tbl[5]  = mk(1,0, 0,0,0,0, 0);
      tbl[6]  = mk(1,0, 0,1,0,0, 0);  tbl[7]  = mk(1,0, 0,1,0,0, 0);
      tbl[8]  = mk(1,0, 0,1,0,0, 0);  tbl[9]  = mk(1,0, 1,0,1,0, 0);
      tbl[10] = mk(1,0, 1,0,0,0, 0);  tbl[11] = mk(1,0, 1,0,0,0, 0);
      tbl[12] = mk(0,0, 1,0,0,0, 0);  tbl[13] = mk(0,0, 1,0,0,0, 0);
      tbl[14] = mk(1,0, 1,1,0,0, 0);  tbl[15] = mk(1,0, 1,1,0,0, 0);
      tbl[16] = mk(1,0, 1,0,0,0, 1);  tbl[17] = mk(1,0, 1,0,0,0, 1);
      tbl[18] = mk(0,0, 1,0,0,0, 1);  tbl[19] = mk(0,0, 1,0,0,0, 1);
      tbl[20] = mk(0,0, 1,1,0,0, 1);  tbl[21] = mk(0,0, 1,1,0,0, 1);
      tbl[22] = mk(0,0, 1,1,0,0, 1);  tbl[23] = mk(0,0, 0,0,0,1, 1);
      tbl[24] = mk(0,0, 0,0,0,0, 1);

      raw_in = 1'b0;
      reset  = 1'b1;
      model_reset();
      @(negedge clk);

      for (int i = 0; i < 25; i++) begin
         edge_step(tbl[i].raw, tbl[i].rst);
         chk($sformatf("tbl%0d_d", i),      32'(d_out),        32'(tbl[i].d));
         chk($sformatf("tbl%0d_busy", i),   32'(busy),         32'(tbl[i].b));
         chk($sformatf("tbl%0d_rise", i),   32'(rise_pulse),   32'(tbl[i].r));
         chk($sformatf("tbl%0d_fall", i),   32'(fall_pulse),   32'(tbl[i].f));
         chk($sformatf("tbl%0d_glitch", i), 32'(glitch_count), 32'(tbl[i].g));
      end

      // bounce 1,0,1,0,1 then hold 1: two aborts, rise on 10th edge
      for (int i = 0; i < 10; i++) begin
         r = (i < 5) ? ((i % 2) == 0) : 1'b1;
         edge_step(r, 1'b0);
         if (i == 8) chk("bounce_d_before", 32'(d_out), 32'd0);
      end
      chk("bounce_d_after", 32'(d_out),        32'd1);
      chk("bounce_rise",    32'(rise_pulse),   32'd1);
      chk("bounce_glitch",  32'(glitch_count), 32'd3);

      // return low, start qualifying a rise, then reset mid-WAIT_HI
      for (int i = 0; i < 8; i++) edge_step(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) edge_step(1'b1, 1'b0);
      chk("midwait_busy", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_async_d",      32'(d_out),        32'd0);
      chk("rst_async_busy",   32'(busy),         32'd0);
      chk("rst_async_glitch", 32'(glitch_count), 32'd0);
      chk("rst_async_rise",   32'(rise_pulse),   32'd0);
      model_reset();
      edge_step(1'b1, 1'b1);

      // release with raw_in high: full latency before d_out rises
      lat = 0;
      for (int i = 1; i <= 12 && lat == 0; i++) begin
         edge_step(1'b1, 1'b0);
         if (d_out === 1'b1) lat = i;
      end
      chk("release_latency", 32'(lat), 32'd6);

      // saturation: 300 two-cycle high glitches from a low level
      edge_step(1'b0, 1'b1);
      edge_step(1'b0, 1'b1);
      for (int n = 0; n < 300; n++) begin
         edge_step(1'b1, 1'b0);
         edge_step(1'b1, 1'b0);
         edge_step(1'b0, 1'b0);
         edge_step(1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) edge_step(1'b0, 1'b0);
      chk("sat_glitch", 32'(glitch_count), 32'd255);
      chk("sat_d",      32'(d_out),        32'd0);

      // random traffic with occasional resets
      edge_step(1'b0, 1'b1);
      r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) r = ~r;
         edge_step(r, ($urandom_range(0, 299) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
